// File: rtl/sb_pkg.sv
// Store buffer shared types: sizes, entry record and the 8-bit
// wrap-around overlap test used by load matching.
package sb_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW = 64;
    localparam int SB_DW = 64;
    localparam int SB_IW = 8;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

    // Two 8-byte ranges overlap when their starts are within 7 either way.
    function automatic logic overlap8(
        input logic [SB_IW-1:0] a,
        input logic [SB_IW-1:0] b
    );
        logic [SB_IW-1:0] d;
        d = a - b;
        return (d <= 8'd7) || (d >= 8'd249);
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Datapath/memory-side bundle of the store buffer.
// master = datapath and memory, slave = the buffer itself.
interface store_buffer_if #(
    parameter int AW = 64,
    parameter int DW = 64,
    parameter int CW = 3
);
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          ld_conflict;
    logic          drain_en;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [CW-1:0] count;
    logic          empty;

    modport master (
        output st_valid, st_addr, st_data,
        output ld_valid, ld_addr, drain_en,
        input  st_ready, ld_hit, ld_data, ld_conflict,
        input  mem_write, mem_addr, mem_wdata, count, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data,
        input  ld_valid, ld_addr, drain_en,
        output st_ready, ld_hit, ld_data, ld_conflict,
        output mem_write, mem_addr, mem_wdata, count, empty
    );
endinterface

// File: rtl/sb_match.sv
// Load lookup: exact 8-bit index hit on the youngest valid entry,
// otherwise report any partial 8-byte overlap as a conflict.
module sb_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  sb_entry_t                  ent [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   tail,
    input  logic                       ld_valid,
    input  logic [SB_IW-1:0]           ld_idx,
    output logic                       hit,
    output logic [$clog2(DEPTH)-1:0]   hit_idx,
    output logic                       conflict
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] p;
    logic          any_ovl;
    logic          unused_bits;

    // Walk from the youngest slot back; the first equal index wins.
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        any_ovl = 1'b0;
        p = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            p = tail - PW'(k);
            if (ent[p].valid) begin
                if (!hit && ent[p].addr[SB_IW-1:0] == ld_idx) begin
                    hit = 1'b1;
                    hit_idx = p;
                end
                if (overlap8(ent[p].addr[SB_IW-1:0], ld_idx))
                    any_ovl = 1'b1;
            end
        end
        if (!ld_valid) begin
            hit = 1'b0;
            hit_idx = '0;
        end
        conflict = ld_valid && !hit && any_ovl;
    end

    always_comb begin
        unused_bits = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            unused_bits = unused_bits
                ^ (^ent[k].addr[SB_AW-1:SB_IW])
                ^ (^ent[k].data);
    end

endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer between the datapath and a single-port data memory,
// with combinational store-to-load forwarding.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW = SB_AW,
    parameter int DW = SB_DW
) (
    input logic          clock,
    input logic          reset,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic [DEPTH-1:0] vld;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    sb_entry_t     ent [DEPTH];

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          hit;
    logic [PW-1:0] hit_idx;
    logic          conflict;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign push  = bus.st_valid && !full;
    assign pop   = !empty && bus.drain_en;

    always_ff @(posedge clock) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            vld  <= '0;
        end else begin
            if (push) begin
                vld[tail] <= 1'b1;
                tail <= tail + 1'b1;
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head <= head + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Payload is left untouched by reset; vld alone gates it.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[tail] <= bus.st_addr;
            data_q[tail] <= bus.st_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent[i].valid = vld[i];
            ent[i].addr  = addr_q[i];
            ent[i].data  = data_q[i];
        end
    end

    sb_match #(
        .DEPTH(DEPTH)
    ) u_match (
        .ent      (ent),
        .tail     (tail),
        .ld_valid (bus.ld_valid),
        .ld_idx   (bus.ld_addr[SB_IW-1:0]),
        .hit      (hit),
        .hit_idx  (hit_idx),
        .conflict (conflict)
    );

    assign bus.st_ready    = !full;
    assign bus.empty       = empty;
    assign bus.count       = cnt;
    assign bus.mem_write   = pop;
    assign bus.mem_addr    = empty ? '0 : addr_q[head];
    assign bus.mem_wdata   = empty ? '0 : data_q[head];
    assign bus.ld_hit      = hit;
    assign bus.ld_data     = hit ? data_q[hit_idx] : '0;
    assign bus.ld_conflict = conflict;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: vector table plus a queue model
// for full/wrap traffic and a reset-while-draining sequence.
module tb_store_buffer;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    store_buffer_if #(.AW(64), .DW(64), .CW(3)) sb_bus ();

    store_buffer #(.DEPTH(4), .AW(64), .DW(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sb_bus)
    );

    typedef struct {
        logic        sv;
        logic [7:0]  sa;
        logic [15:0] sd;
        logic        lv;
        logic [15:0] la;
        logic        dr;
        logic        rdy;
        int          cnt;
        logic        mw;
        logic [7:0]  ma;
        logic [15:0] md;
        logic        hit;
        logic [15:0] ld;
        logic        cf;
    } vec_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
    } ent_t;

    vec_t tbl[$];
    ent_t q[$];
    int errors = 0;
    int checks = 0;

    function automatic vec_t mk(
        input logic sv, input logic [7:0] sa, input logic [15:0] sd,
        input logic lv, input logic [15:0] la, input logic dr,
        input logic rdy, input int cnt, input logic mw,
        input logic [7:0] ma, input logic [15:0] md,
        input logic hit, input logic [15:0] ld, input logic cf
    );
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd;
        v.lv = lv; v.la = la; v.dr = dr;
        v.rdy = rdy; v.cnt = cnt; v.mw = mw;
        v.ma = ma; v.md = md;
        v.hit = hit; v.ld = ld; v.cf = cf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [63:0] sa,
                         input logic [63:0] sd, input logic lv,
                         input logic [63:0] la, input logic dr);
        sb_bus.st_valid = sv;
        sb_bus.st_addr  = sa;
        sb_bus.st_data  = sd;
        sb_bus.ld_valid = lv;
        sb_bus.ld_addr  = la;
        sb_bus.drain_en = dr;
    endtask

    // Model step: checks outputs against q, then applies push/pop.
    task automatic mstep(input logic sv, input logic [63:0] sa,
                         input logic [63:0] sd, input logic dr);
        bit acc;
        bit pp;
        ent_t e;
        @(negedge clock);
        drive(sv, sa, sd, 1'b0, 64'd0, dr);
        #1;
        acc = sv && (q.size() < 4);
        pp = dr && (q.size() > 0);
        chk("m_count", 64'(sb_bus.count), 64'(q.size()));
        chk("m_ready", 64'(sb_bus.st_ready), 64'(q.size() < 4));
        chk("m_write", 64'(sb_bus.mem_write), 64'(pp));
        if (q.size() > 0) begin
            chk("m_addr", sb_bus.mem_addr, q[0].a);
            chk("m_wdata", sb_bus.mem_wdata, q[0].d);
        end
        if (pp) void'(q.pop_front());
        if (acc) begin
            e.a = sa;
            e.d = sd;
            q.push_back(e);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);

        // After reset
        tbl.push_back(mk(0,8'h00,16'h00,0,16'h0,0, 1,0,0,8'h00,16'h00,0,16'h0,0));
        // Single store, held, then drained
        tbl.push_back(mk(1,8'h08,16'h32,0,16'h0,0, 1,0,0,8'h00,16'h00,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,0,16'h0,0, 1,1,0,8'h08,16'h32,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,0,16'h0,1, 1,1,1,8'h08,16'h32,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,0,16'h0,0, 1,0,0,8'h00,16'h00,0,16'h0,0));
        // Fill to four, fifth ignored, drain in order
        tbl.push_back(mk(1,8'h00,16'hA0,0,16'h0,0, 1,0,0,8'h00,16'h00,0,16'h0,0));
        tbl.push_back(mk(1,8'h08,16'hA1,0,16'h0,0, 1,1,0,8'h00,16'hA0,0,16'h0,0));
        tbl.push_back(mk(1,8'h10,16'hA2,0,16'h0,0, 1,2,0,8'h00,16'hA0,0,16'h0,0));
        tbl.push_back(mk(1,8'h18,16'hA3,0,16'h0,0, 1,3,0,8'h00,16'hA0,0,16'h0,0));
        tbl.push_back(mk(1,8'h20,16'hA4,0,16'h0,0, 0,4,0,8'h00,16'hA0,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,0,16'h0,1, 0,4,1,8'h00,16'hA0,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,0,16'h0,1, 1,3,1,8'h08,16'hA1,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,0,16'h0,1, 1,2,1,8'h10,16'hA2,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,0,16'h0,1, 1,1,1,8'h18,16'hA3,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,0,16'h0,1, 1,0,0,8'h00,16'h00,0,16'h0,0));
        // Youngest-wins forwarding and partial overlap
        tbl.push_back(mk(1,8'h28,16'h64,0,16'h0,0, 1,0,0,8'h00,16'h00,0,16'h0,0));
        tbl.push_back(mk(1,8'h28,16'h99,0,16'h0,0, 1,1,0,8'h28,16'h64,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'h28,0, 1,2,0,8'h28,16'h64,1,16'h99,0));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'h2C,0, 1,2,0,8'h28,16'h64,0,16'h0,1));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'h30,0, 1,2,0,8'h28,16'h64,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'h21,0, 1,2,0,8'h28,16'h64,0,16'h0,1));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'h20,0, 1,2,0,8'h28,16'h64,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'h2F,0, 1,2,0,8'h28,16'h64,0,16'h0,1));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'h128,0, 1,2,0,8'h28,16'h64,1,16'h99,0));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'h28,1, 1,2,1,8'h28,16'h64,1,16'h99,0));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'h28,1, 1,1,1,8'h28,16'h99,1,16'h99,0));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'h28,0, 1,0,0,8'h00,16'h00,0,16'h0,0));
        // Same-cycle push is not forwarded
        tbl.push_back(mk(1,8'h50,16'h77,1,16'h50,0, 1,0,0,8'h00,16'h00,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'h50,0, 1,1,0,8'h50,16'h77,1,16'h77,0));
        tbl.push_back(mk(0,8'h00,16'h00,0,16'h50,1, 1,1,1,8'h50,16'h77,0,16'h0,0));
        // Overlap across the 8-bit index wrap
        tbl.push_back(mk(1,8'hFC,16'h55,0,16'h0,0, 1,0,0,8'h00,16'h00,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'h02,0, 1,1,0,8'hFC,16'h55,0,16'h0,1));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'h04,0, 1,1,0,8'hFC,16'h55,0,16'h0,0));
        tbl.push_back(mk(0,8'h00,16'h00,1,16'hFC,1, 1,1,1,8'hFC,16'h55,1,16'h55,0));
        tbl.push_back(mk(0,8'h00,16'h00,0,16'h00,0, 1,0,0,8'h00,16'h00,0,16'h0,0));

        repeat (2) @(negedge clock);
        #1;
        chk("rst_count", 64'(sb_bus.count), 64'd0);
        chk("rst_empty", 64'(sb_bus.empty), 64'd1);
        reset = 1'b0;

        foreach (tbl[i]) begin
            vec_t v;
            v = tbl[i];
            @(negedge clock);
            drive(v.sv, 64'(v.sa), 64'(v.sd), v.lv, 64'(v.la), v.dr);
            #1;
            chk($sformatf("v%0d ready", i), 64'(sb_bus.st_ready), 64'(v.rdy));
            chk($sformatf("v%0d count", i), 64'(sb_bus.count), 64'(v.cnt));
            chk($sformatf("v%0d empty", i), 64'(sb_bus.empty), 64'(v.cnt == 0));
            chk($sformatf("v%0d write", i), 64'(sb_bus.mem_write), 64'(v.mw));
            chk($sformatf("v%0d maddr", i), sb_bus.mem_addr, 64'(v.ma));
            chk($sformatf("v%0d wdata", i), sb_bus.mem_wdata, 64'(v.md));
            chk($sformatf("v%0d hit", i), 64'(sb_bus.ld_hit), 64'(v.hit));
            chk($sformatf("v%0d ldata", i), sb_bus.ld_data, 64'(v.ld));
            chk($sformatf("v%0d confl", i), 64'(sb_bus.ld_conflict), 64'(v.cf));
        end

        // Full buffer with push and drain together, then wrap traffic
        q.delete();
        for (int i = 0; i < 4; i++)
            mstep(1, 64'h40 + 64'(8 * i), 64'h100 + 64'(i), 0);
        mstep(1, 64'h60, 64'h1F0, 1);
        mstep(1, 64'h60, 64'h1F0, 0);
        for (int i = 0; i < 10; i++)
            mstep(1, 64'h80 + 64'(8 * i), 64'h200 + 64'(i), 1);
        for (int i = 0; i < 5; i++)
            mstep(0, 64'h0, 64'h0, 1);
        chk("wrap_drained", 64'(q.size()), 64'd0);

        // Reset while draining three stores
        for (int i = 0; i < 3; i++)
            mstep(1, 64'h70 + 64'(8 * i), 64'h300 + 64'(i), 0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        #1;
        chk("rd_pre_write", 64'(sb_bus.mem_write), 64'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rd_write", 64'(sb_bus.mem_write), 64'd0);
        chk("rd_count", 64'(sb_bus.count), 64'd0);
        chk("rd_empty", 64'(sb_bus.empty), 64'd1);
        chk("rd_maddr", sb_bus.mem_addr, 64'd0);
        @(negedge clock);
        drive(0, 0, 0, 1, 64'h70, 0);
        #1;
        chk("rd_hit70", 64'(sb_bus.ld_hit), 64'd0);
        chk("rd_cf70", 64'(sb_bus.ld_conflict), 64'd0);
        chk("rd_ld70", sb_bus.ld_data, 64'd0);
        @(negedge clock);
        drive(0, 0, 0, 1, 64'h80, 0);
        #1;
        chk("rd_hit80", 64'(sb_bus.ld_hit), 64'd0);
        chk("rd_ready", 64'(sb_bus.st_ready), 64'd1);
        q.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; power of two, 2..16.
REQ-002 Parameter AW, default 64, store/load address width.
REQ-003 Parameter DW, default 64, store data width, one doubleword.
REQ-004 Port clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port st_valid  in  1  datapath presents a store this cycle.
REQ-007 Port st_ready  out  1  buffer can accept a store (not full).
REQ-008 Port st_addr  in  AW  store byte address.
REQ-009 Port st_data  in  DW  store doubleword.
REQ-010 Port ld_valid  in  1  datapath load lookup this cycle.
REQ-011 Port ld_addr  in  AW  load byte address.
REQ-012 Port ld_hit  out  1  buffered store exactly matches the load.
REQ-013 Port ld_data  out  DW  forwarded doubleword; valid when ld_hit=1.
REQ-014 Port ld_conflict  out  1  partial overlap; datapath must stall the load.
REQ-015 Port drain_en  in  1  data memory port is free for a write this cycle.
REQ-016 Port mem_write  out  1  drives the data memory MemWrite.
REQ-017 Port mem_addr  out  AW  head entry address to the data memory.
REQ-018 Port mem_wdata  out  DW  head entry data to the data memory.
REQ-019 Port count  out  clog2(DEPTH)+1  number of occupied entries.
REQ-020 Port empty  out  1  count equals 0.

Function
REQ-021 Ordering SHALL be FIFO: stores drain to memory in acceptance order.
REQ-022 Push SHALL occur on a rising edge with st_valid=1 and st_ready=1; the entry is written at the tail and the tail advances modulo DEPTH.
REQ-023 st_ready SHALL be 1 exactly when count<DEPTH; a full buffer rejects a push even if a pop happens in the same cycle.
REQ-024 mem_write SHALL be combinational: 1 exactly when empty=0 and drain_en=1; mem_addr/mem_wdata SHALL show the head entry whenever empty=0, else 0.
REQ-025 Pop SHALL occur on every edge where mem_write=1; the head advances modulo DEPTH.
REQ-026 Push and pop in the same edge SHALL leave count unchanged.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication of entries.
REQ-028 Load matching SHALL compare only ld_addr[7:0] against each valid entry's addr[7:0] (256-byte memory index space).
REQ-029 ld_hit SHALL be 1 when ld_valid=1 and some valid entry has an equal 8-bit index; ld_data SHALL come from the youngest such entry.
REQ-030 ld_conflict SHALL be 1 when ld_valid=1, ld_hit=0, and some valid entry's 8-byte range [a,a+7] overlaps [ld,ld+7] under 8-bit wrap-around.
REQ-031 When ld_hit=0, ld_data SHALL be 0; when ld_valid=0, ld_hit and ld_conflict SHALL be 0.
REQ-032 Lookup SHALL see only entries present before the current edge; a store pushed in the same cycle is not forwarded.
REQ-033 The head entry being popped in the current cycle SHALL still be eligible for forwarding.
REQ-034 Lookup SHALL be combinational with zero latency; push-to-memory latency SHALL be at least one cycle.

Reset
REQ-035 Reset SHALL set head, tail and count to 0 and clear all entry-valid bits.
REQ-036 After reset, outputs SHALL be: st_ready=1, empty=1, mem_write=0, ld_hit=0, ld_conflict=0, mem_addr=0, mem_wdata=0, ld_data=0.
REQ-037 Reset SHALL take priority over a simultaneous push or pop; pending stores are discarded and the data array is not cleared.

Structure
REQ-038 Package sb_pkg SHALL hold DEPTH, AW, DW, the memory index width (8) and the entry record type {valid, addr, data}.
REQ-039 The match logic SHALL be a single sub-module, sb_match, that takes the entry array plus head/tail and returns hit, youngest index and conflict.

Verification
REQ-040 Reset, then push addr 0x08 data 0x32 with drain_en=0 -> count=1, mem_addr=0x08, mem_wdata=0x32, mem_write=0; raise drain_en -> one mem_write pulse, then empty=1.
REQ-041 Push 4 stores (0x00,0x08,0x10,0x18) with drain_en=0 -> st_ready=0 at count=4; a fifth st_valid is ignored; drain -> writes appear in order 0x00,0x08,0x10,0x18.
REQ-042 Push 0x28/data 0x64, then 0x28/data 0x99; load 0x28 -> ld_hit=1, ld_data=0x99; load 0x2C -> ld_conflict=1, ld_hit=0.
REQ-043 When full, set st_valid=1 and drain_en=1 together -> one pop only, count goes 4 to 3; next cycle the push is accepted; run 10 push/pop cycles so pointers wrap with the data intact.
REQ-044 Same cycle: push 0x50 and load 0x50 -> ld_hit=0; the next cycle -> ld_hit=1 with the stored data.
REQ-045 Assert reset with 3 entries while drain_en=1 -> mem_write=0 on the next cycle, count=0, and later loads do not hit the stale addresses.
